// File: rtl/fft_pkg.sv
// Shared FFT datapath package.
// Holds the word format and the fixed-point scaling of the 32-point radix-2 FFT.
// It also holds the sign-magnitude word type, the twiddle constant tables and a
// sign-magnitude add helper that the butterfly-side stages use.
package fft_pkg;

  localparam int number_bits = 22;
  localparam int N           = 32;
  localparam int Q           = 8;
  localparam int K_W         = $clog2(N/2);
  localparam int MAG_W       = number_bits - 1;

  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  // Bit [number_bits-1] is the sign (1 = negative); the rest is the magnitude.
  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_t;

  // round(2^Q * cos(2*pi*k/N)), magnitude part, k = 0..N/2-1.
  localparam logic [Q:0] cos_mag [N/2] = '{
    9'd256, 9'd251, 9'd237, 9'd213, 9'd181, 9'd142, 9'd98,  9'd50,
    9'd0,   9'd50,  9'd98,  9'd142, 9'd181, 9'd213, 9'd237, 9'd251
  };

  // Sign of the cosine term: bit k set means negative (k = 9..15).
  localparam logic [N/2-1:0] cos_sign = 16'hFE00;

  // round(2^Q * sin(2*pi*k/N)). The twiddle imaginary part is the negation of
  // this, so its sign is 1 wherever the magnitude is non-zero.
  localparam logic [Q:0] sin_mag [N/2] = '{
    9'd0,   9'd50,  9'd98,  9'd142, 9'd181, 9'd213, 9'd237, 9'd251,
    9'd256, 9'd251, 9'd237, 9'd213, 9'd181, 9'd142, 9'd98,  9'd50
  };

  // Clears the sign of a zero magnitude so -0 never propagates.
  function automatic sm_t sm_norm(sm_t x);
    sm_t r;
    r = x;
    if (x.mag == '0) r.sign = 1'b0;
    return r;
  endfunction

  // Sign-magnitude addition with saturation on like-signed overflow.
  // Unlike signs subtract smaller from larger and keep the sign of the larger.
  function automatic sm_t sm_add(sm_t x, sm_t y);
    sm_t          r;
    logic [MAG_W:0] sum;
    sum = '0;
    if (x.sign == y.sign) begin
      sum    = {1'b0, x.mag} + {1'b0, y.mag};
      r.sign = x.sign;
      r.mag  = sum[MAG_W] ? MAG_MAX : sum[MAG_W-1:0];
    end else if (x.mag >= y.mag) begin
      r.sign = x.sign;
      r.mag  = x.mag - y.mag;
    end else begin
      r.sign = y.sign;
      r.mag  = y.mag - x.mag;
    end
    if (r.mag == '0) r.sign = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sm_mult_q.sv
// Combinational sign-magnitude Q-format multiplier.
//   x, y : sign-magnitude operands (fft_pkg::sm_t)
//   p    : product, magnitude = (|x|*|y| + 2^(Q-1)) >> Q (round half up),
//          saturated to MAG_MAX, sign forced to 0 on a zero magnitude.
module sm_mult_q
  import fft_pkg::*;
(
  input  sm_t x,
  input  sm_t y,
  output sm_t p
);

  localparam int PW = 2*MAG_W + 1;

  localparam logic [PW-1:0] HALF    = PW'(1) << (Q-1);
  localparam logic [PW-1:0] SAT_LIM = PW'(MAG_MAX);

  logic [PW-1:0] prod;
  logic [PW-1:0] rounded;
  logic [PW-1:0] scaled;

  always_comb begin
    prod    = PW'(x.mag) * PW'(y.mag);
    rounded = prod + HALF;
    scaled  = rounded >> Q;
    p.mag   = (scaled > SAT_LIM) ? MAG_MAX : scaled[MAG_W-1:0];
    p.sign  = (p.mag == '0) ? 1'b0 : (x.sign ^ y.sign);
  end

endmodule

// File: rtl/twiddle_mult.sv
// Pipelined complex twiddle multiplier for the 32-point radix-2 FFT.
// Computes (a + jb) * W_N^k with W = c + jd, c = cos term, d = -sin term:
//   re = a*c - b*d,  im = a*d + b*c   (sign-magnitude, Q fractional bits).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_re, in_im, in_k sampled on accept
//   out_valid / out_ready output handshake; out_re, out_im result words
// Handshake: a word moves on any edge where valid && ready are both high.
// The three stages move together whenever the output slot is free or is being
// drained (adv). While stalled every stage holds, bubbles included, so outputs
// stay stable and in_ready is low. Latency is 3 cycles when never stalled.
module twiddle_mult
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [number_bits-1:0] in_re,
  input  logic [number_bits-1:0] in_im,
  input  logic [K_W-1:0]         in_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [number_bits-1:0] out_re,
  output logic [number_bits-1:0] out_im
);

  logic adv;

  // S1: operands and twiddle constants
  logic v1;
  sm_t  a1, b1, c1, d1;
  // S2: rounded/saturated partial products
  logic v2;
  sm_t  ac2, bd2, ad2, bc2;
  // S3: result
  sm_t  re3, im3;

  sm_t c_rom, d_rom;
  sm_t ac_p, bd_p, ad_p, bc_p;
  sm_t bd_neg, re_n, im_n;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  // Twiddle lookup; the sin term is always stored negated, zero stays +0.
  always_comb begin
    c_rom.sign = cos_sign[in_k];
    c_rom.mag  = MAG_W'(cos_mag[in_k]);
    d_rom.sign = (sin_mag[in_k] != '0);
    d_rom.mag  = MAG_W'(sin_mag[in_k]);
  end

  sm_mult_q u_mul_ac (.x(a1), .y(c1), .p(ac_p));
  sm_mult_q u_mul_bd (.x(b1), .y(d1), .p(bd_p));
  sm_mult_q u_mul_ad (.x(a1), .y(d1), .p(ad_p));
  sm_mult_q u_mul_bc (.x(b1), .y(c1), .p(bc_p));

  // re = ac - bd is done as ac + (-bd); sm_add fixes up a -0 result.
  always_comb begin
    bd_neg.sign = ~bd2.sign;
    bd_neg.mag  = bd2.mag;
    re_n        = sm_add(ac2, bd_neg);
    im_n        = sm_add(ad2, bc2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      c1        <= '0;
      d1        <= '0;
      v2        <= 1'b0;
      ac2       <= '0;
      bd2       <= '0;
      ad2       <= '0;
      bc2       <= '0;
      out_valid <= 1'b0;
      re3       <= '0;
      im3       <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= sm_norm(in_re);
        b1 <= sm_norm(in_im);
        c1 <= c_rom;
        d1 <= d_rom;
      end
      v2        <= v1;
      ac2       <= ac_p;
      bd2       <= bd_p;
      ad2       <= ad_p;
      bc2       <= bc_p;
      out_valid <= v2;
      re3       <= re_n;
      im3       <= im_n;
    end
  end

  assign out_re = re3;
  assign out_im = im3;

endmodule

// File: tb/tb_twiddle_mult.sv
// Bench for twiddle_mult: behavioural complex-multiply model, expected queue,
// per-cycle compare process, directed literal cases and randomized streaming.
module tb_twiddle_mult;

  localparam int W = 22;
  localparam longint MAXM = (64'd1 << (W-1)) - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re, in_im;
  logic [3:0]   in_k;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re, out_im;

  int vectors;
  int miscompares;
  int out_count;

  logic [2*W-1:0] exp_q[$];

  twiddle_mult dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic longint sm2i(logic [W-1:0] x);
    longint m;
    m = longint'(x[W-2:0]);
    return x[W-1] ? -m : m;
  endfunction

  function automatic logic [W-1:0] i2sm(longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m > MAXM) m = MAXM;
    if (v < 0 && m != 0) return {1'b1, m[W-2:0]};
    return {1'b0, m[W-2:0]};
  endfunction

  function automatic longint round_real(real r);
    if (r >= 0.0) return longint'($floor(r + 0.5));
    return -longint'($floor(-r + 0.5));
  endfunction

  function automatic longint qmul(longint x, longint y);
    longint m;
    m = (((x < 0) ? -x : x) * ((y < 0) ? -y : y) + 128) / 256;
    if (m > MAXM) m = MAXM;
    return ((x < 0) != (y < 0)) ? -m : m;
  endfunction

  function automatic logic [2*W-1:0] model(logic [W-1:0] a, logic [W-1:0] b, int k);
    real    ang;
    longint c, d, av, bv, re, im;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / 32.0;
    c   = round_real(256.0 * $cos(ang));
    d   = -round_real(256.0 * $sin(ang));
    av  = sm2i(a);
    bv  = sm2i(b);
    re  = qmul(av, c) - qmul(bv, d);
    im  = qmul(av, d) + qmul(bv, c);
    return {i2sm(re), i2sm(im)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  logic         prev_stall;
  logic         prev_rst;
  logic [W-1:0] prev_re, prev_im;

  initial begin
    prev_stall = 1'b0;
    prev_rst   = 1'b1;
    prev_re    = '0;
    prev_im    = '0;
  end

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      check("rst_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      if (prev_rst) check("post_rst_out_valid", 64'(out_valid), 64'd0);
      if (prev_stall) check("stall_stable", {20'd0, out_re, out_im}, {20'd0, prev_re, prev_im});
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          check("stream_result", {20'd0, out_re, out_im}, {20'd0, e});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_re, in_im, int'(in_k)));
      prev_stall = out_valid && !out_ready;
      prev_re    = out_re;
      prev_im    = out_im;
      prev_rst   = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; holds the word until accepted, returns at the
  // falling edge after the accepting edge with in_valid low.
  task automatic push_item(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] k);
    in_valid = 1'b1;
    in_re = a; in_im = b; in_k = k;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("push_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic directed(string name, logic [W-1:0] a, logic [W-1:0] b,
                          logic [3:0] k, logic [2*W-1:0] lit);
    int lat;
    check({name, "_model"}, 64'(model(a, b, int'(k))), 64'(lit));
    out_ready = 1'b1;
    in_valid = 1'b1; in_re = a; in_im = b; in_k = k;
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      #1;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_value"}, {20'd0, out_re, out_im}, {20'd0, lit});
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-2:0] m;
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = '1;
      2:       m = (W-1)'($urandom_range(0, 1000));
      default: m = (W-1)'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic last_acc;
    vectors = 0; miscompares = 0; out_count = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0; in_k = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_re", 64'(out_re), 64'd0);
    check("reset_out_im", 64'(out_im), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    // directed literal cases
    directed("k0",   22'd256, 22'd0, 4'd0, {22'd256, 22'd0});
    directed("k8",   22'd256, 22'd0, 4'd8, {22'd0, 1'b1, 21'd256});
    directed("k4",   22'd256, 22'd0, 4'd4, {22'd181, 1'b1, 21'd181});
    directed("sat",  {1'b0, 21'h1FFFFF}, {1'b0, 21'h1FFFFF}, 4'd4,
             {1'b0, 21'h1FFFFF, 22'd0});
    directed("negzero", {1'b1, 21'd0}, 22'd0, 4'd5, 44'd0);
    directed("k12",  22'd1000, 22'd0, 4'd12, {1'b1, 21'd707, 1'b1, 21'd707});

    // backpressure: fill the pipe with out_ready low
    base = out_count;
    out_ready = 1'b0;
    push_item(22'd1, 22'd0, 4'd0);
    push_item(22'd2, 22'd0, 4'd0);
    push_item(22'd3, 22'd0, 4'd0);
    in_valid = 1'b1; in_re = 22'd4; in_im = '0; in_k = '0;
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_re", 64'(out_re), 64'd1);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    push_item(22'd4, 22'd0, 4'd0);
    repeat (6) @(negedge clk);
    check("bp_out_count", 64'(out_count - base), 64'd4);

    // mid-stream reset
    out_ready = 1'b0;
    push_item(22'd77, 22'd5, 4'd3);
    push_item(22'd88, 22'd6, 4'd7);
    rst = 1'b1;
    in_valid = 1'b1; in_re = 22'd99; in_im = '0; in_k = '0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    base = out_count;
    repeat (8) @(negedge clk);
    check("rst_no_stale", 64'(out_count - base), 64'd0);

    // randomized streaming
    last_acc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_re = rand_word();
        in_im = rand_word();
        in_k  = 4'($urandom_range(0, 15));
      end
      #1;
      last_acc = in_valid && in_ready;
      @(negedge clk);
    end

    // drain
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && (exp_q.size() != 0 || out_valid); n++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
